// File: rtl/tbird_lamp_monitor.sv
// Checker for the Thunderbird tail-lamp bus: decodes left/right/hazard sequences,
// checks step order and hold time. Define TBIRD_MON_COUNT_EN to keep completion counters.
module tbird_lamp_monitor #(
    parameter int STEP_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             LA,
    input  logic             LB,
    input  logic             LC,
    input  logic             RA,
    input  logic             RB,
    input  logic             RC,
    output logic [1:0]       mode,
    output logic             seq_done,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] left_cnt,
    output logic [CNT_W-1:0] right_cnt,
    output logic [CNT_W-1:0] haz_cnt
);

    // Step states share their numbering with the pattern codes below,
    // so "same pattern" and "next pattern" are plain compares.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_L1     = 4'd1, S_L2 = 4'd2, S_L3 = 4'd3,
        S_R1     = 4'd4, S_R2 = 4'd5, S_R3 = 4'd6,
        S_H1     = 4'd7, S_H2 = 4'd8, S_H3 = 4'd9,
        S_RESYNC = 4'd10
    } state_t;

    localparam logic [3:0] P_OFF = 4'd0;
    localparam logic [3:0] P_L1  = 4'd1;
    localparam logic [3:0] P_R1  = 4'd4;
    localparam logic [3:0] P_H1  = 4'd7;
    localparam logic [3:0] P_ILL = 4'd15;

    localparam logic [2:0] E_ILLEGAL = 3'd1;
    localparam logic [2:0] E_ORDER   = 3'd2;
    localparam logic [2:0] E_SHORT   = 3'd3;
    localparam logic [2:0] E_LONG    = 3'd4;

    localparam logic [7:0] STEP = STEP_CYCLES[7:0];

    state_t     state_q, state_d;
    logic [3:0] pat, prev_q, succ;
    logic [7:0] run_q, run_d;
    logic [2:0] cause;
    logic       done_d;
    logic [1:0] mode_d;

    always_comb begin
        pat = P_ILL;
        case ({LA, LB, LC, RA, RB, RC})
            6'b000_000: pat = 4'd0;
            6'b100_000: pat = 4'd1;
            6'b110_000: pat = 4'd2;
            6'b111_000: pat = 4'd3;
            6'b000_100: pat = 4'd4;
            6'b000_110: pat = 4'd5;
            6'b000_111: pat = 4'd6;
            6'b100_100: pat = 4'd7;
            6'b110_110: pat = 4'd8;
            6'b111_111: pat = 4'd9;
            default:    pat = P_ILL;
        endcase
    end

    // Run length of the current pattern; run_q == 0 only straight after reset.
    always_comb begin
        run_d = 8'd1;
        if (run_q != 8'd0 && pat == prev_q)
            run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
    end

    always_comb begin
        state_d = state_q;
        cause   = 3'd0;
        done_d  = 1'b0;
        case (state_q)
            S_L3, S_R3, S_H3: succ = P_OFF;
            default:          succ = state_q + 4'd1;
        endcase
        case (state_q)
            S_RESYNC: begin
                if (pat == P_OFF) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (pat == P_ILL)
                    cause = E_ILLEGAL;
                else if (pat == P_L1 || pat == P_R1 || pat == P_H1)
                    state_d = state_t'(pat);
                else if (pat != P_OFF)
                    cause = E_ORDER;
            end
            default: begin
                if (pat == P_ILL) begin
                    cause = E_ILLEGAL;
                end else if (pat == state_q) begin
                    if (run_q == STEP) cause = E_LONG;
                end else if (pat == succ) begin
                    if (run_q < STEP) begin
                        cause = E_SHORT;
                    end else if (pat == P_OFF) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = state_t'(succ);
                    end
                end else begin
                    cause = E_ORDER;
                end
            end
        endcase
        if (cause != 3'd0)
            state_d = (pat == P_OFF) ? S_IDLE : S_RESYNC;
    end

    always_comb begin
        mode_d = 2'b00;
        case (state_d)
            S_L1, S_L2, S_L3: mode_d = 2'b01;
            S_R1, S_R2, S_R3: mode_d = 2'b10;
            S_H1, S_H2, S_H3: mode_d = 2'b11;
            default:          mode_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_RESYNC;
            run_q    <= 8'd0;
            prev_q   <= P_OFF;
            mode     <= 2'b00;
            seq_done <= 1'b0;
            err      <= 1'b0;
            err_code <= 3'd0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            prev_q   <= pat;
            mode     <= mode_d;
            seq_done <= done_d;
            err      <= (cause != 3'd0);
            if (cause != 3'd0) err_code <= cause;
        end
    end

`ifdef TBIRD_MON_COUNT_EN
    logic [CNT_W-1:0] left_q, right_q, haz_q;

    // mode still names the finishing sequence on its OFF edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            left_q  <= '0;
            right_q <= '0;
            haz_q   <= '0;
        end else if (done_d) begin
            case (mode)
                2'b01:   if (left_q  != '1) left_q  <= left_q  + CNT_W'(1);
                2'b10:   if (right_q != '1) right_q <= right_q + CNT_W'(1);
                2'b11:   if (haz_q   != '1) haz_q   <= haz_q   + CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign left_cnt  = left_q;
    assign right_cnt = right_q;
    assign haz_cnt   = haz_q;
`else
    assign left_cnt  = '0;
    assign right_cnt = '0;
    assign haz_cnt   = '0;
`endif

endmodule

// File: doc/tbird_lamp_monitor.md
# tbird_lamp_monitor

- Checks the six tail-lamp outputs of the Thunderbird light controller, one sample per clock edge.
- Decodes which sequence is running (left, right or hazard).
- Checks that the patterns arrive in the legal order and that each step is held for the legal time.
- Reports a completion pulse when a sequence finishes cleanly, or an error pulse with a cause code when it does not.
- Sits alongside the controller on the lamp bus as its checker, for the board self-test and for simulation.

## Interface
- STEP_CYCLES, 1: number of clocks each non-off lamp pattern must be held, range 1..255.
- CNT_W, 8: width of the sequence counters.
- clk  in  1  system clock; all logic updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- LA, LB, LC  in  1 each  left lamps; LA is the innermost.
- RA, RB, RC  in  1 each  right lamps; RA is the innermost.
- mode  out  2  sequence in progress: 00 idle, 01 left, 10 right, 11 hazard.
- seq_done  out  1  one-cycle pulse when a sequence completes cleanly.
- err  out  1  one-cycle pulse when a violation is detected.
- err_code  out  3  cause of the latest error; holds its value until the next error or reset.
- left_cnt, right_cnt, haz_cnt  out  CNT_W each  counts of completed sequences (see Configuration).

## Operation
- Legal patterns, written {LA LB LC, RA RB RC}:
  - OFF = 000,000.
  - Left steps: L1 = 100,000; L2 = 110,000; L3 = 111,000.
  - Right steps: R1 = 000,100; R2 = 000,110; R3 = 000,111.
  - Hazard steps: H1 = 100,100; H2 = 110,110; H3 = 111,111.
- States: RESYNC, IDLE, and one state per step: L1–L3, R1–R3, H1–H3.
- Legal transitions:
  - IDLE -> L1, R1 or H1; IDLE stays in IDLE on OFF.
  - X1 -> X2 -> X3 -> OFF (IDLE).
  - A step pattern repeats while its run count is below STEP_CYCLES.
- Run counter: 8 bits, saturating.
  - Loads 1 when a new pattern is sampled.
  - Increments on each edge where the same pattern is sampled again.
  - Not checked while in IDLE.
- Error causes, highest priority first; at most one is reported per edge:
  - 1 ILLEGAL: sampled pattern is none of the ten legal patterns.
  - 2 ORDER: a legal pattern that is not a legal successor. This includes OFF after X1 or X2, and X2 or X3 sampled while in IDLE.
  - 3 SHORT: the pattern changed to a legal successor while run < STEP_CYCLES.
  - 4 LONG: the same step pattern was sampled with run == STEP_CYCLES, i.e. it is being held too long.
- On an error:
  - err pulses and err_code is loaded; mode goes to 00.
  - Next state is IDLE if the offending sample was OFF, otherwise RESYNC.
- RESYNC:
  - No checks are made and no errors are flagged.
  - Exits to IDLE on the first OFF sample.
- mode:
  - Set on the X1 entry edge.
  - Held through X2 and X3.
  - Cleared on the OFF edge that ends the sequence.
- seq_done pulses on the X3 -> OFF edge when that X3 run equals STEP_CYCLES.

## Timing
- Outputs are registered and reflect the pattern sampled at the same edge. This is one cycle after the controller drives the pattern.
- Reset:
  - State goes to RESYNC.
  - mode = 00, seq_done = 0, err = 0, err_code = 000, run = 0, all counters = 0.
  - Reset has priority over every other event.
  - Reset asserted in the middle of a sequence discards it. After release, the block waits in RESYNC for OFF, so no spurious error is raised.
- seq_done and err are never high on the same edge. seq_done only fires on a fully legal OFF edge.
- LONG is reported on the edge of the (STEP_CYCLES+1)-th identical sample. After it the state is RESYNC, so the stuck pattern produces no repeat errors.
- OFF has no minimum or maximum duration.
- X3 -> X1 with no OFF between them is ORDER.

## Configuration
- TBIRD_MON_COUNT_EN defined:
  - On each seq_done, left_cnt, right_cnt or haz_cnt increments according to the mode that just completed.
  - Each counter saturates at 2^CNT_W-1.
- TBIRD_MON_COUNT_EN undefined: the three counters are absent from the logic and their outputs are tied to 0. All other behaviour is identical.

## Test plan
All scenarios use STEP_CYCLES = 2 and CNT_W = 8.
- Left sequence, each step held 2 clocks, then OFF:
  - mode = 01 from the L1 edge through the L3 edges.
  - seq_done pulses on the OFF edge; err = 0.
  - left_cnt = 1 when TBIRD_MON_COUNT_EN is defined.
- Hazard sequence with H2 held 1 clock: err pulses on the H3 edge with err_code = 3; then RESYNC until OFF.
- R1 held 3 clocks: err pulses on the 3rd R1 edge with err_code = 4; mode returns to 00.
- IDLE, then pattern 101,000: err_code = 1. IDLE, then L2: err_code = 2. L1 then OFF: err_code = 2, next state IDLE.
- reset low during L2, released while L3 is on the bus: no err; seq_done stays 0 until a full clean sequence follows.
- 255 clean right sequences, then 1 more: right_cnt saturates at 255.
